// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Glyph table is active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg7_polarity(
    input logic [6:0] seg,
    input logic       act_low
  );
    return act_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-high glyph decoder.
// One instance serves the currently scanned digit.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    o_glyph = SEG_GLYPH[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multi-digit seven-segment scan controller with digit register file.
// One guard cycle per slot keeps anodes dark while segments settle.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [AW-1:0]         scan_idx
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = $clog2(REFRESH_DIV);

  localparam logic SEG_LOW = (SEG_ACT_LOW != 0);
  localparam logic AN_LOW  = (AN_ACT_LOW != 0);

  localparam logic [6:0] SEG_OFF =
    seg7_polarity(SEG_BLANK, SEG_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{AN_LOW}};

  logic [3:0]       r_nib [DEPTH];
  logic [DEPTH-1:0] r_dp;
  logic [DEPTH-1:0] r_blank;

  logic [PW-1:0] r_pre;
  logic [AW-1:0] r_scan;

  logic [6:0]            r_seg;
  logic                  r_dp_o;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_wr_ok;
  logic                  w_wrap;
  logic                  w_guard;
  logic [3:0]            w_cur_nib;
  logic                  w_cur_dp;
  logic                  w_cur_blank;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_act;
  logic                  w_dp_act;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [NUM_DIGITS-1:0] w_an_act;

  assign w_wr_ok = wr_en && (32'(wr_addr) < NUM_DIGITS);
  assign w_wrap  = (r_pre == PW'(REFRESH_DIV - 1));
  assign w_guard = (r_pre == '0);

  // Digit register file; addresses past the last digit are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_nib[i] <= '0;
      end
      r_dp    <= '0;
      r_blank <= '1;
    end else if (w_wr_ok) begin
      r_nib[wr_addr]   <= wr_data;
      r_dp[wr_addr]    <= wr_dp;
      r_blank[wr_addr] <= wr_blank;
    end
  end

  // Prescaler and digit scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_scan <= '0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) begin
        r_scan <= (r_scan == AW'(NUM_DIGITS - 1))
                ? '0 : r_scan + 1'b1;
      end
    end
  end

  assign w_cur_nib   = r_nib[r_scan];
  assign w_cur_dp    = r_dp[r_scan];
  assign w_cur_blank = r_blank[r_scan];

  seg7_hex_decode u_dec (
    .i_nibble (w_cur_nib),
    .o_glyph  (w_glyph)
  );

  // Active-high view of the next pin values
  always_comb begin
    w_an_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_hot[i] = (r_scan == AW'(i));
    end
    w_seg_act = w_cur_blank ? SEG_BLANK : w_glyph;
    w_dp_act  = w_cur_dp & ~w_cur_blank;
    w_an_act  = (w_guard | w_cur_blank) ? '0 : w_an_hot;
  end

  // Output register stage with pin polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= SEG_OFF;
      r_dp_o <= SEG_LOW;
      r_an   <= AN_OFF;
    end else begin
      r_seg  <= seg7_polarity(w_seg_act, SEG_LOW);
      r_dp_o <= w_dp_act ^ SEG_LOW;
      r_an   <= AN_LOW ? ~w_an_act : w_an_act;
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp_o;
  assign an       = r_an;
  assign scan_idx = r_scan;

endmodule
